// File: rtl/hsv_pkg.sv
// Shared widths, sector constants and stage payload types for the RGB-to-HSV pipeline.
package hsv_pkg;

  localparam int HUE_W    = 9;
  localparam int HUE_FULL = 360;
  localparam int BASE_R   = 0;
  localparam int BASE_G   = 120;
  localparam int BASE_B   = 240;

  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sec_e;

  // Per-pixel hue control carried from the max/min stage to the hue assembly stage.
  typedef struct packed {
    sec_e sec;
    logic neg;
    logic dz;
  } hue_ctl_t;

  function automatic logic [HUE_W:0] sector_base(input sec_e sec);
    case (sec)
      SEC_G:   return (HUE_W+1)'(BASE_G);
      SEC_B:   return (HUE_W+1)'(BASE_B);
      default: return (HUE_W+1)'(BASE_R);
    endcase
  endfunction

endpackage

// File: rtl/hsv_stream_converter_if.sv
// Pixel-in / HSV-out stream bundle; threshold window and mask exist only with HSV_THRESH_EN.
interface hsv_stream_converter_if #(
  parameter int DW = 8,
  parameter int UW = 2
);
  logic                       s_valid;
  logic                       s_ready;
  logic [DW-1:0]              s_r;
  logic [DW-1:0]              s_g;
  logic [DW-1:0]              s_b;
  logic [UW-1:0]              s_user;
  logic                       m_valid;
  logic                       m_ready;
  logic [hsv_pkg::HUE_W-1:0]  m_h;
  logic [DW-1:0]              m_s;
  logic [DW-1:0]              m_v;
  logic [UW-1:0]              m_user;
`ifdef HSV_THRESH_EN
  logic [hsv_pkg::HUE_W-1:0]  h_lo;
  logic [hsv_pkg::HUE_W-1:0]  h_hi;
  logic [DW-1:0]              s_lo;
  logic [DW-1:0]              s_hi;
  logic [DW-1:0]              v_lo;
  logic [DW-1:0]              v_hi;
  logic                       m_mask;

  modport slave (
    input  s_valid, s_r, s_g, s_b, s_user, m_ready,
    input  h_lo, h_hi, s_lo, s_hi, v_lo, v_hi,
    output s_ready, m_valid, m_h, m_s, m_v, m_user, m_mask
  );
  modport master (
    output s_valid, s_r, s_g, s_b, s_user, m_ready,
    output h_lo, h_hi, s_lo, s_hi, v_lo, v_hi,
    input  s_ready, m_valid, m_h, m_s, m_v, m_user, m_mask
  );
`else
  modport slave (
    input  s_valid, s_r, s_g, s_b, s_user, m_ready,
    output s_ready, m_valid, m_h, m_s, m_v, m_user
  );
  modport master (
    output s_valid, s_r, s_g, s_b, s_user, m_ready,
    input  s_ready, m_valid, m_h, m_s, m_v, m_user
  );
`endif
endinterface

// File: rtl/hsv_hue_div.sv
// Registered stage-3 divides: q = 60*n/delta and sat = delta*(2^DW-1)/max, enabled by adv.
module hsv_hue_div #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic [DW-1:0] n,
  input  logic [DW-1:0] delta,
  input  logic [DW-1:0] max_v,
  output logic [6:0]    q,
  output logic [DW-1:0] sat
);

  logic [DW+5:0]   num_q, den_q, quo_q;
  logic [2*DW-1:0] num_s, den_s, quo_s;

  // Zero denominators are replaced by 1 so the divider never sees 0; the result is forced below.
  always_comb begin
    num_q = (DW+6)'(n) * (DW+6)'(60);
    den_q = (delta == '0) ? (DW+6)'(1) : (DW+6)'(delta);
    quo_q = num_q / den_q;
    num_s = (2*DW)'(delta) * (2*DW)'({DW{1'b1}});
    den_s = (max_v == '0) ? (2*DW)'(1) : (2*DW)'(max_v);
    quo_s = num_s / den_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= '0;
    end else if (adv) begin
      q   <= (delta == '0) ? 7'd0 : 7'(quo_q);
      sat <= (max_v == '0) ? '0 : DW'(quo_s);
    end
  end

endmodule

// File: rtl/hsv_stream_converter.sv
// Global-stall RGB-to-HSV pipeline, 4 cycles latency (5 with HSV_THRESH_EN adding the window mask).
// s_ready = !m_valid || m_ready; every stage, valids included, loads only on that advance.
module hsv_stream_converter
  import hsv_pkg::*;
#(
  parameter int DW = 8,
  parameter int UW = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  hsv_stream_converter_if.slave bus
);

  logic adv;
  assign adv         = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = adv;

  // Stage 1: input capture
  logic          v1;
  logic [DW-1:0] r1, g1, b1;
  logic [UW-1:0] u1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; r1 <= '0; g1 <= '0; b1 <= '0; u1 <= '0;
    end else if (adv) begin
      v1 <= bus.s_valid; r1 <= bus.s_r; g1 <= bus.s_g; b1 <= bus.s_b; u1 <= bus.s_user;
    end
  end

  // Stage 2: max/min, sector and signed numerator
  logic [DW-1:0] mx_c, mn_c, x_c, y_c;
  sec_e          sec_c;

  always_comb begin
    sec_c = SEC_R; mx_c = r1; x_c = g1; y_c = b1;
    if (r1 >= g1 && r1 >= b1) begin
      sec_c = SEC_R; mx_c = r1; x_c = g1; y_c = b1;
    end else if (g1 >= b1) begin
      sec_c = SEC_G; mx_c = g1; x_c = b1; y_c = r1;
    end else begin
      sec_c = SEC_B; mx_c = b1; x_c = r1; y_c = g1;
    end
    mn_c = r1;
    if (g1 < mn_c) mn_c = g1;
    if (b1 < mn_c) mn_c = b1;
  end

  logic          v2;
  logic [DW-1:0] mx2, dl2, n2;
  hue_ctl_t      ctl2;
  logic [UW-1:0] u2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; mx2 <= '0; dl2 <= '0; n2 <= '0; ctl2 <= '0; u2 <= '0;
    end else if (adv) begin
      v2       <= v1;
      mx2      <= mx_c;
      dl2      <= mx_c - mn_c;
      n2       <= (x_c < y_c) ? (y_c - x_c) : (x_c - y_c);
      ctl2.sec <= sec_c;
      ctl2.neg <= (x_c < y_c);
      ctl2.dz  <= (mx_c == mn_c);
      u2       <= u1;
    end
  end

  // Stage 3: divides in the sub-module, sideband carried alongside
  logic          v3;
  logic [DW-1:0] mx3, sat3;
  logic [6:0]    q3;
  hue_ctl_t      ctl3;
  logic [UW-1:0] u3;

  hsv_hue_div #(.DW(DW)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .n     (n2),
    .delta (dl2),
    .max_v (mx2),
    .q     (q3),
    .sat   (sat3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; mx3 <= '0; ctl3 <= '0; u3 <= '0;
    end else if (adv) begin
      v3 <= v2; mx3 <= mx2; ctl3 <= ctl2; u3 <= u2;
    end
  end

  // Stage 4: hue assembly; the r sector with neg counts down from 360, and 360 folds to 0
  logic [HUE_W:0]   base_c, hsum_c;
  logic [HUE_W-1:0] h_c;

  always_comb begin
    base_c = sector_base(ctl3.sec);
    if (ctl3.neg)
      hsum_c = ((ctl3.sec == SEC_R) ? (HUE_W+1)'(HUE_FULL) : base_c) - (HUE_W+1)'(q3);
    else
      hsum_c = base_c + (HUE_W+1)'(q3);
    if (ctl3.dz || hsum_c == (HUE_W+1)'(HUE_FULL))
      h_c = '0;
    else
      h_c = HUE_W'(hsum_c);
  end

  logic             v4;
  logic [HUE_W-1:0] h4;
  logic [DW-1:0]    s4, vv4;
  logic [UW-1:0]    u4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4 <= 1'b0; h4 <= '0; s4 <= '0; vv4 <= '0; u4 <= '0;
    end else if (adv) begin
      v4 <= v3; h4 <= h_c; s4 <= sat3; vv4 <= mx3; u4 <= u3;
    end
  end

`ifdef HSV_THRESH_EN
  // Stage 5: window compare against the thresholds present this cycle
  logic h_ok, s_ok, v_ok;

  always_comb begin
    if (bus.h_lo <= bus.h_hi)
      h_ok = (h4 >= bus.h_lo) && (h4 <= bus.h_hi);
    else
      h_ok = (h4 >= bus.h_lo) || (h4 <= bus.h_hi);
    s_ok = (s4 >= bus.s_lo) && (s4 <= bus.s_hi);
    v_ok = (vv4 >= bus.v_lo) && (vv4 <= bus.v_hi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0; bus.m_h <= '0; bus.m_s <= '0; bus.m_v <= '0;
      bus.m_user  <= '0;   bus.m_mask <= 1'b0;
    end else if (adv) begin
      bus.m_valid <= v4; bus.m_h <= h4; bus.m_s <= s4; bus.m_v <= vv4;
      bus.m_user  <= u4; bus.m_mask <= h_ok && s_ok && v_ok;
    end
  end
`else
  assign bus.m_valid = v4;
  assign bus.m_h     = h4;
  assign bus.m_s     = s4;
  assign bus.m_v     = vv4;
  assign bus.m_user  = u4;
`endif

endmodule

// File: tb/tb_hsv_stream_converter.sv
// Directed-vector bench for hsv_stream_converter: colour points, backpressure, bubbles, reset, mask.
module tb_hsv_stream_converter;

  localparam int DW = 8;
  localparam int UW = 2;
`ifdef HSV_THRESH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int NV = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsv_stream_converter_if #(.DW(DW), .UW(UW)) bus ();

  hsv_stream_converter #(.DW(DW), .UW(UW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Hand-computed colour points: r, g, b -> h, s, v
  int vr[NV] = '{255,   0,   0, 100, 0, 255, 255, 128, 255,   0, 200,  50,  10, 255, 255};
  int vg[NV] = '{  0, 255,   0, 100, 0,   0,   0, 255, 255, 128, 100, 200,  20,   0,  43};
  int vb[NV] = '{  0,   0, 255, 100, 0, 128,   1,   0,   0, 255,  50, 100,  30,  43,   0};
  int vh[NV] = '{  0, 120, 240,   0, 0, 330,   0,  90,  60, 210,  20, 140, 210, 350,  10};
  int vs[NV] = '{255, 255, 255,   0, 0, 255, 255, 255, 255, 255, 191, 191, 170, 255, 255};
  int vv[NV] = '{255, 255, 255, 100, 0, 255, 255, 255, 255, 255, 200, 200,  30, 255, 255};

  typedef struct {
    int h;
    int s;
    int v;
    int u;
    int mk;
    int c;
  } rec_t;

  rec_t outq[$];
  int   accq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (rst_n && bus.s_valid && bus.s_ready) accq.push_back(cyc);
    if (bus.m_valid && bus.m_ready) begin
      r.h = int'(bus.m_h); r.s = int'(bus.m_s); r.v = int'(bus.m_v); r.u = int'(bus.m_user);
`ifdef HSV_THRESH_EN
      r.mk = int'(bus.m_mask);
`else
      r.mk = 0;
`endif
      r.c = cyc;
      outq.push_back(r);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input int user);
    bus.s_valid = 1'b1;
    bus.s_r     = DW'(vr[idx]);
    bus.s_g     = DW'(vg[idx]);
    bus.s_b     = DW'(vb[idx]);
    bus.s_user  = UW'(user);
  endtask

  task automatic expect_out(input string tag, input int idx, input int user, input bit chk_lat);
    rec_t r;
    int   a;
    chk({tag, "_present"}, int'(outq.size() > 0), 1);
    if (outq.size() > 0) begin
      r = outq.pop_front();
      chk({tag, "_h"}, r.h, vh[idx]);
      chk({tag, "_s"}, r.s, vs[idx]);
      chk({tag, "_v"}, r.v, vv[idx]);
      chk({tag, "_user"}, r.u, user);
      if (accq.size() > 0) begin
        a = accq.pop_front();
        if (chk_lat) chk({tag, "_lat"}, r.c - a, LAT);
      end
    end
  endtask

  initial begin
    int p;
    bit acc;
    int hold;

    bus.s_valid = 1'b0; bus.s_r = '0; bus.s_g = '0; bus.s_b = '0; bus.s_user = '0;
    bus.m_ready = 1'b1;
`ifdef HSV_THRESH_EN
    bus.h_lo = 9'd330; bus.h_hi = 9'd30;
    bus.s_lo = 8'd0;   bus.s_hi = 8'd255;
    bus.v_lo = 8'd0;   bus.v_hi = 8'd255;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_s_ready", int'(bus.s_ready), 1);
    chk("rst_m_h", int'(bus.m_h), 0);
    chk("rst_m_s", int'(bus.m_s), 0);
    chk("rst_m_v", int'(bus.m_v), 0);
    chk("rst_m_user", int'(bus.m_user), 0);
    bus.m_ready = 1'b0;
    #1;
    chk("rst_s_ready_noready", int'(bus.s_ready), 1);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Colour points back-to-back
    for (int i = 0; i < 9; i++) begin
      drive(i, i % 4);
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("pts_count", outq.size(), 9);
    for (int i = 0; i < 9; i++) expect_out($sformatf("pt%0d", i), i, i % 4, 1'b1);

    // Backpressure: m_ready low for stream cycles 6..15
    hold = 6 - LAT;
    p = 0;
    for (int k = 0; k < 34; k++) begin
      bus.m_ready = !(k >= 6 && k <= 15);
      if (p < 16) drive(p % NV, p % 4);
      else bus.s_valid = 1'b0;
      @(negedge clk);
      if (k == 8 || k == 15) begin
        chk($sformatf("bp_hold_valid_k%0d", k), int'(bus.m_valid), 1);
        chk($sformatf("bp_hold_h_k%0d", k), int'(bus.m_h), vh[hold]);
        chk($sformatf("bp_hold_s_k%0d", k), int'(bus.m_s), vs[hold]);
        chk($sformatf("bp_hold_v_k%0d", k), int'(bus.m_v), vv[hold]);
        chk($sformatf("bp_hold_user_k%0d", k), int'(bus.m_user), hold % 4);
      end
      if (k == 10) chk("bp_s_ready_stall", int'(bus.s_ready), 0);
      acc = bus.s_valid && bus.s_ready;
      tick();
      if (acc) p++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (LAT + 2) tick();
    chk("bp_count", outq.size(), 16);
    for (int i = 0; i < 16; i++) expect_out($sformatf("bp%0d", i), i % NV, i % 4, 1'b0);

    // Bubbles: s_valid toggling each cycle
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) drive(9 + k / 2, k / 2);
      else bus.s_valid = 1'b0;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("bub_count", outq.size(), 5);
    for (int i = 0; i < 5; i++) expect_out($sformatf("bub%0d", i), 9 + i, i % 4, 1'b1);

    // Reset with pixels in flight
    for (int i = 0; i <= LAT; i++) begin
      drive(i, 1);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("rs_pre_valid", int'(bus.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid_drop", int'(bus.m_valid), 0);
    chk("rs_h_clear", int'(bus.m_h), 0);
    repeat (2) tick();
    outq.delete();
    accq.delete();
    rst_n = 1'b1;
    tick();
    drive(5, 3);
    tick();
    bus.s_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("rs_post_count", outq.size(), 1);
    expect_out("rs_post", 5, 3, 1'b1);

`ifdef HSV_THRESH_EN
    // Hue window wrapping through 0: 330..30
    drive(13, 0); tick();
    drive(14, 1); tick();
    drive(8, 2);  tick();
    bus.s_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("th_count", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("th_h350", outq[0].h, 350);
      chk("th_mask350", outq[0].mk, 1);
      chk("th_h10", outq[1].h, 10);
      chk("th_mask10", outq[1].mk, 1);
      chk("th_h60", outq[2].h, 60);
      chk("th_mask60", outq[2].mk, 0);
      chk("th_lat", outq[0].c - accq[0], LAT);
    end
    outq.delete();
    accq.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
